// File: rtl/bcd_convert.sv
// bcd_convert: 16-bit binary to 5-digit BCD via shift-and-add-3, with a hex bypass
// and registered result/display words that stay stable for the scan driver.
module bcd_convert (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic        hex_mode,
   output logic        out_valid,
   output logic [19:0] bcd,
   output logic [15:0] disp_data,
   output logic        ovf
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t      state_q, state_d;
   logic [15:0] sr_q, sr_d;
   logic [19:0] scr_q, scr_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        hex_q, hex_d;
   logic        vld_q, vld_d;
   logic [19:0] bcd_q, bcd_d;
   logic [15:0] disp_q, disp_d;
   logic        ovf_q, ovf_d;
   logic [19:0] adj;
   logic [35:0] sh;
   logic        dec_ovf;
   for (genvar d = 0; d < 5; d++) begin : g_adj
      assign adj[4*d+:4] = (scr_q[4*d+:4] >= 4'd5) ? scr_q[4*d+:4] + 4'd3 : scr_q[4*d+:4];
   end
   // The top scratch bit can never be set after an add-3 step, so dropping it is lossless.
   assign sh      = {adj[18:0], sr_q, 1'b0};
   assign dec_ovf = scr_q[19:16] != 4'd0;
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      hex_d   = hex_q;
      vld_d   = 1'b0;
      bcd_d   = bcd_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: if (in_valid) begin
            sr_d    = in_data;
            hex_d   = hex_mode;
            scr_d   = '0;
            cnt_d   = '0;
            state_d = hex_mode ? DONE : SHIFT;
         end
         SHIFT: begin
            scr_d   = sh[35:16];
            sr_d    = sh[15:0];
            cnt_d   = cnt_q + 5'd1;
            state_d = (cnt_q == 5'd15) ? DONE : SHIFT;
         end
         DONE: begin
            vld_d   = 1'b1;
            state_d = IDLE;
            bcd_d   = hex_q ? {4'h0, sr_q} : scr_q;
            ovf_d   = !hex_q && dec_ovf;
            disp_d  = hex_q ? sr_q : (dec_ovf ? 16'h9999 : scr_q[15:0]);
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         hex_q   <= 1'b0;
         vld_q   <= 1'b0;
         bcd_q   <= '0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         hex_q   <= hex_d;
         vld_q   <= vld_d;
         bcd_q   <= bcd_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
      end
   end
   assign in_ready  = state_q == IDLE;
   assign out_valid = vld_q;
   assign bcd       = bcd_q;
   assign disp_data = disp_q;
   assign ovf       = ovf_q;
endmodule

// File: tb/tb_bcd_convert.sv
// tb_bcd_convert: directed and random checks of bcd_convert latency, results,
// busy rejection, mid-conversion reset and scratch digit range.
module tb_bcd_convert;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        hex_mode = 1'b0;
   logic        out_valid;
   logic [19:0] bcd;
   logic [15:0] disp_data;
   logic        ovf;
   int          n_assert = 0;
   int          n_fail = 0;

   bcd_convert dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .hex_mode(hex_mode), .out_valid(out_valid),
      .bcd(bcd), .disp_data(disp_data), .ovf(ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      for (int i = 0; i < 5; i++) begin
         r[4*i+:4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic send(input logic [15:0] v, input logic h);
      int guard;
      guard = 0;
      in_data  = v;
      hex_mode = h;
      in_valid = 1'b1;
      while (!in_ready && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      n_assert++;
      if (!in_ready) begin
         n_fail++;
         $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Waits for out_valid after an accept, also checking scratch digits stay <= 9 every cycle.
   task automatic wait_out(output int cyc, output bit rdy_low, output bit stable);
      logic [36:0] held;
      logic [19:0] s;
      held    = {bcd, disp_data, ovf};
      rdy_low = 1'b1;
      stable  = 1'b1;
      cyc     = 0;
      while (cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         s = dut.scr_q;
         n_assert++;
         if (s[3:0] > 4'd9 || s[7:4] > 4'd9 || s[11:8] > 4'd9 || s[15:12] > 4'd9 || s[19:16] > 4'd9) begin
            n_fail++;
            $display("FAIL digit_range: scratch=%05h required every digit <= 9", s);
         end
         if (out_valid) break;
         if (in_ready) rdy_low = 1'b0;
         if ({bcd, disp_data, ovf} !== held) stable = 1'b0;
      end
      if (!out_valid) cyc = 999;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      n_assert += 5;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b required 1", in_ready); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", out_valid); end
      if (bcd !== 20'h0) begin n_fail++; $display("FAIL rst_bcd: got %05h required 00000", bcd); end
      if (disp_data !== 16'h0) begin n_fail++; $display("FAIL rst_disp: got %04h required 0000", disp_data); end
      if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b required 0", ovf); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_decimal;
      int cyc;
      bit rl, st;
      send(16'h04D2, 1'b0);
      wait_out(cyc, rl, st);
      n_assert += 5;
      if (cyc != 17) begin n_fail++; $display("FAIL dec_latency: got %0d required 17", cyc); end
      if (!rl) begin n_fail++; $display("FAIL dec_ready_low: in_ready rose before result"); end
      if (bcd !== 20'h01234) begin n_fail++; $display("FAIL dec_bcd: got %05h required 01234", bcd); end
      if (disp_data !== 16'h1234) begin n_fail++; $display("FAIL dec_disp: got %04h required 1234", disp_data); end
      if (ovf !== 1'b0) begin n_fail++; $display("FAIL dec_ovf: got %b required 0", ovf); end
      @(posedge clk); #1;
      n_assert += 2;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dec_pulse_len: out_valid=%b required 0", out_valid); end
      if (bcd !== 20'h01234) begin n_fail++; $display("FAIL dec_hold: got %05h required 01234", bcd); end
   endtask

   task automatic test_boundaries;
      logic [15:0] vals [4] = '{16'd0, 16'd9999, 16'd10000, 16'd65535};
      logic [19:0] eb   [4] = '{20'h00000, 20'h09999, 20'h10000, 20'h65535};
      logic [15:0] ed   [4] = '{16'h0000, 16'h9999, 16'h9999, 16'h9999};
      logic        eo   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      int cyc;
      bit rl, st;
      for (int i = 0; i < 4; i++) begin
         send(vals[i], 1'b0);
         wait_out(cyc, rl, st);
         n_assert += 4;
         if (cyc != 17) begin n_fail++; $display("FAIL bnd_latency[%0d]: got %0d required 17", vals[i], cyc); end
         if (bcd !== eb[i]) begin n_fail++; $display("FAIL bnd_bcd[%0d]: got %05h required %05h", vals[i], bcd, eb[i]); end
         if (disp_data !== ed[i]) begin n_fail++; $display("FAIL bnd_disp[%0d]: got %04h required %04h", vals[i], disp_data, ed[i]); end
         if (ovf !== eo[i]) begin n_fail++; $display("FAIL bnd_ovf[%0d]: got %b required %b", vals[i], ovf, eo[i]); end
      end
   endtask

   task automatic test_hex;
      int cyc;
      bit rl, st;
      send(16'hBEEF, 1'b1);
      wait_out(cyc, rl, st);
      n_assert += 5;
      if (cyc != 1) begin n_fail++; $display("FAIL hex_latency: got %0d required 1", cyc); end
      if (bcd !== 20'h0BEEF) begin n_fail++; $display("FAIL hex_bcd: got %05h required 0BEEF", bcd); end
      if (disp_data !== 16'hBEEF) begin n_fail++; $display("FAIL hex_disp: got %04h required BEEF", disp_data); end
      if (ovf !== 1'b0) begin n_fail++; $display("FAIL hex_ovf: got %b required 0", ovf); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hex_ready: got %b required 1", in_ready); end
   endtask

   task automatic test_back_to_back;
      int cyc;
      bit rl, st;
      send(16'd42, 1'b0);
      cyc = 0;
      while (cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 5) begin
            in_data  = 16'h1111;
            hex_mode = 1'b0;
            in_valid = 1'b1;
         end
         if (out_valid) break;
      end
      n_assert += 3;
      if (cyc != 17) begin n_fail++; $display("FAIL busy_latency: got %0d required 17", cyc); end
      if (bcd !== 20'h00042) begin n_fail++; $display("FAIL busy_first: got %05h required 00042", bcd); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL busy_ready: got %b required 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_assert++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_accept: in_ready=%b required 0", in_ready); end
      wait_out(cyc, rl, st);
      n_assert += 3;
      if (cyc != 17) begin n_fail++; $display("FAIL busy_second_latency: got %0d required 17", cyc); end
      if (bcd !== 20'h04369) begin n_fail++; $display("FAIL busy_second: got %05h required 04369", bcd); end
      if (disp_data !== 16'h4369) begin n_fail++; $display("FAIL busy_second_disp: got %04h required 4369", disp_data); end
   endtask

   task automatic test_reset_mid;
      int cyc, pulses;
      bit rl, st;
      send(16'd500, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_assert += 5;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b required 1", in_ready); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b required 0", out_valid); end
      if (bcd !== 20'h0) begin n_fail++; $display("FAIL mid_bcd: got %05h required 00000", bcd); end
      if (disp_data !== 16'h0) begin n_fail++; $display("FAIL mid_disp: got %04h required 0000", disp_data); end
      if (ovf !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %b required 0", ovf); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      n_assert++;
      if (pulses != 0) begin n_fail++; $display("FAIL mid_no_pulse: got %0d pulses required 0", pulses); end
      send(16'd77, 1'b0);
      wait_out(cyc, rl, st);
      n_assert += 2;
      if (cyc != 17) begin n_fail++; $display("FAIL mid_after_latency: got %0d required 17", cyc); end
      if (bcd !== 20'h00077) begin n_fail++; $display("FAIL mid_after_bcd: got %05h required 00077", bcd); end
   endtask

   task automatic test_random;
      int cyc, v, ecyc;
      bit h, rl, st;
      logic [19:0] eb;
      logic [15:0] ed;
      logic eo;
      for (int i = 0; i < 2000; i++) begin
         v = int'($urandom_range(0, 65535));
         h = 1'($urandom_range(0, 1));
         send(16'(v), h);
         wait_out(cyc, rl, st);
         eb   = h ? {4'h0, 16'(v)} : to_bcd(v);
         eo   = !h && v > 9999;
         ed   = h ? 16'(v) : (eo ? 16'h9999 : eb[15:0]);
         ecyc = h ? 1 : 17;
         n_assert += 5;
         if (cyc != ecyc) begin n_fail++; $display("FAIL rnd_latency[%0d h%0b]: got %0d required %0d", v, h, cyc, ecyc); end
         if (bcd !== eb) begin n_fail++; $display("FAIL rnd_bcd[%0d h%0b]: got %05h required %05h", v, h, bcd, eb); end
         if (disp_data !== ed) begin n_fail++; $display("FAIL rnd_disp[%0d h%0b]: got %04h required %04h", v, h, disp_data, ed); end
         if (ovf !== eo) begin n_fail++; $display("FAIL rnd_ovf[%0d h%0b]: got %b required %b", v, h, ovf, eo); end
         if (!st) begin n_fail++; $display("FAIL rnd_stable[%0d]: outputs changed before out_valid, required held", v); end
      end
   endtask

   initial begin
      test_reset;
      test_decimal;
      test_boundaries;
      test_hex;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
